// File: rtl/gray_mod_7_monitor_if.sv
// ============================================================================
// Module      : gray_mod_7_monitor_if
// Description : Bus between the mod-7 Gray counter and its monitor.
//               GRAY_MON_SEG7_EN adds the registered seven-segment output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gray_mod_7_monitor_if;
  logic [2:0] g;
  logic       rs;
  logic [2:0] b;
  logic       vld;
  logic       wrap;
  logic [7:0] wcnt;
  logic       err;
  logic       ill;
`ifdef GRAY_MON_SEG7_EN
  logic [6:0] seg;

  modport master (output g, rs, input b, vld, wrap, wcnt, err, ill, seg);
  modport slave  (input g, rs, output b, vld, wrap, wcnt, err, ill, seg);
`else
  modport master (output g, rs, input b, vld, wrap, wcnt, err, ill);
  modport slave  (input g, rs, output b, vld, wrap, wcnt, err, ill);
`endif
endinterface

`default_nettype wire

// File: rtl/gray_mod_7_monitor.sv
// ============================================================================
// Module      : gray_mod_7_monitor
// Description : Decodes and checks the 3-bit mod-7 Gray sequence every clock.
//               Optional macro GRAY_MON_SEG7_EN adds a seven-segment output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_mod_7_monitor (
  input  wire logic           ck,
  input  wire logic           clr,
  gray_mod_7_monitor_if.slave bus
);

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam logic [2:0] C_ILLEGAL = 3'b100;
  localparam logic [6:0] C_SEG_ZERO = 7'b1111110;

  function automatic logic [2:0] gray_index(input logic [2:0] code);
    case (code)
      3'b000:  gray_index = 3'd0;
      3'b001:  gray_index = 3'd1;
      3'b011:  gray_index = 3'd2;
      3'b010:  gray_index = 3'd3;
      3'b110:  gray_index = 3'd4;
      3'b111:  gray_index = 3'd5;
      3'b101:  gray_index = 3'd6;
      default: gray_index = 3'd0;
    endcase
  endfunction

  function automatic logic [2:0] gray_succ(input logic [2:0] code);
    case (code)
      3'b000:  gray_succ = 3'b001;
      3'b001:  gray_succ = 3'b011;
      3'b011:  gray_succ = 3'b010;
      3'b010:  gray_succ = 3'b110;
      3'b110:  gray_succ = 3'b111;
      3'b111:  gray_succ = 3'b101;
      3'b101:  gray_succ = 3'b000;
      default: gray_succ = 3'b000;
    endcase
  endfunction

  state_t     state_q, state_d;
  logic [2:0] gq_q, gq_d;
  logic [2:0] b_q, b_d;
  logic       vld_q, vld_d;
  logic       wrap_q, wrap_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic       err_q, err_d;
  logic       ill_q, ill_d;
  logic       w_is_ill;
  logic       w_is_succ;

  assign w_is_ill  = (bus.g == C_ILLEGAL);
  assign w_is_succ = (bus.g == gray_succ(gq_q));

  always_comb begin
    state_d = state_q;
    gq_d    = gq_q;
    b_d     = b_q;
    wcnt_d  = wcnt_q;
    err_d   = err_q;
    wrap_d  = 1'b0;
    ill_d   = 1'b0;

    // Resync overrides all evaluation of g, including the ill pulse.
    if (bus.rs) begin
      state_d = ST_SYNC;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        ST_SYNC: begin
          if (w_is_ill) begin
            ill_d = 1'b1;
          end else begin
            gq_d    = bus.g;
            b_d     = gray_index(bus.g);
            state_d = ST_TRACK;
          end
        end
        ST_TRACK: begin
          if (w_is_succ && !w_is_ill) begin
            gq_d = bus.g;
            b_d  = gray_index(bus.g);
            if (gq_q == 3'b101) begin
              wrap_d = 1'b1;
              if (wcnt_q != 8'hFF) wcnt_d = wcnt_q + 8'd1;
            end
          end else begin
            state_d = ST_FAULT;
            err_d   = 1'b1;
            ill_d   = w_is_ill;
          end
        end
        ST_FAULT: begin
          ill_d = w_is_ill;
        end
        default: begin
          state_d = ST_SYNC;
        end
      endcase
    end

    vld_d = (state_d == ST_TRACK);
  end

  always_ff @(posedge ck) begin
    if (clr) begin
      state_q <= ST_SYNC;
      gq_q    <= 3'b000;
      b_q     <= 3'b000;
      vld_q   <= 1'b0;
      wrap_q  <= 1'b0;
      wcnt_q  <= 8'd0;
      err_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gq_q    <= gq_d;
      b_q     <= b_d;
      vld_q   <= vld_d;
      wrap_q  <= wrap_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
      ill_q   <= ill_d;
    end
  end

  assign bus.b    = b_q;
  assign bus.vld  = vld_q;
  assign bus.wrap = wrap_q;
  assign bus.wcnt = wcnt_q;
  assign bus.err  = err_q;
  assign bus.ill  = ill_q;

`ifdef GRAY_MON_SEG7_EN
  function automatic logic [6:0] seg_pattern(input logic [2:0] digit);
    case (digit)
      3'd0:    seg_pattern = 7'b1111110;
      3'd1:    seg_pattern = 7'b0110000;
      3'd2:    seg_pattern = 7'b1101101;
      3'd3:    seg_pattern = 7'b1111001;
      3'd4:    seg_pattern = 7'b0110011;
      3'd5:    seg_pattern = 7'b1011011;
      3'd6:    seg_pattern = 7'b1011111;
      default: seg_pattern = 7'b0000000;
    endcase
  endfunction

  logic [6:0] seg_q, seg_d;

  assign seg_d = seg_pattern(b_d);

  always_ff @(posedge ck) begin
    if (clr) seg_q <= C_SEG_ZERO;
    else     seg_q <= seg_d;
  end

  assign bus.seg = seg_q;
`else
  logic [6:0] unused_seg_zero;
  assign unused_seg_zero = C_SEG_ZERO;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gray_mod_7_monitor.sv
// ============================================================================
// Module      : tb_gray_mod_7_monitor
// Description : Self-checking bench for gray_mod_7_monitor with a
//               sequence-index reference model and randomized stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gray_mod_7_monitor;

  localparam logic [2:0] SEQ [0:6] = '{3'b000, 3'b001, 3'b011, 3'b010,
                                       3'b110, 3'b111, 3'b101};
  localparam logic [6:0] SEG [0:6] = '{7'b1111110, 7'b0110000, 7'b1101101,
                                       7'b1111001, 7'b0110011, 7'b1011011,
                                       7'b1011111};

  logic ck;
  logic clr;
  gray_mod_7_monitor_if bus();

  gray_mod_7_monitor dut (
    .ck  (ck),
    .clr (clr),
    .bus (bus)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: mode 0 = resynchronising, 1 = tracking, 2 = faulted.
  int         m_mode;
  int         m_gq;
  logic [2:0] m_b;
  logic [7:0] m_wcnt;
  logic       m_err;
  logic       m_wrap;
  logic       m_ill;

  function automatic int find_idx(input logic [2:0] code);
    find_idx = -1;
    for (int i = 0; i < 7; i++) if (SEQ[i] == code) find_idx = i;
  endfunction

  task automatic model_update(input logic [2:0] gv, input logic rsv, input logic clrv);
    int k;
    k = find_idx(gv);
    if (clrv) begin
      m_mode = 0; m_gq = 0; m_b = 3'd0; m_wcnt = 8'd0;
      m_err = 1'b0; m_wrap = 1'b0; m_ill = 1'b0;
    end else begin
      m_wrap = 1'b0;
      m_ill  = 1'b0;
      if (rsv) begin
        m_mode = 0;
        m_err  = 1'b0;
      end else if (m_mode == 0) begin
        if (k < 0) m_ill = 1'b1;
        else begin
          m_gq = k; m_b = 3'(k); m_mode = 1;
        end
      end else if (m_mode == 1) begin
        if (k >= 0 && k == (m_gq + 1) % 7) begin
          if (k == 0) begin
            m_wrap = 1'b1;
            if (m_wcnt < 8'd255) m_wcnt = m_wcnt + 8'd1;
          end
          m_gq = k; m_b = 3'(k);
        end else begin
          m_mode = 2; m_err = 1'b1;
          if (k < 0) m_ill = 1'b1;
        end
      end else begin
        if (k < 0) m_ill = 1'b1;
      end
    end
  endtask

  task automatic step(input logic [2:0] gv, input logic rsv, input logic clrv);
    bus.g  = gv;
    bus.rs = rsv;
    clr    = clrv;
    @(posedge ck);
    model_update(gv, rsv, clrv);
    #1;
  endtask

  task automatic test_reset();
    step(3'b011, 1'b0, 1'b1);
    step(3'b011, 1'b1, 1'b1);
    n_cmp++;
    if ({bus.b, bus.vld, bus.wrap, bus.wcnt, bus.err, bus.ill} !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_outputs: got b=%0d vld=%0b wrap=%0b wcnt=%0d err=%0b ill=%0b, want all 0",
               bus.b, bus.vld, bus.wrap, bus.wcnt, bus.err, bus.ill);
    end
`ifdef GRAY_MON_SEG7_EN
    n_cmp++;
    if (bus.seg !== 7'b1111110) begin
      n_bad++;
      $display("FAIL reset_seg: got %b want 1111110", bus.seg);
    end
`endif
  endtask

  task automatic test_legal_sequence();
    int wraps;
    logic [2:0] exp_b;
    wraps = 0;
    step(3'b000, 1'b0, 1'b1);
    step(3'b000, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) begin
      step(SEQ[i % 7], 1'b0, 1'b0);
      exp_b = 3'(i % 7);
      if (bus.wrap === 1'b1) wraps++;
      n_cmp++;
      if (bus.vld !== 1'b1 || bus.b !== exp_b || bus.wrap !== (i == 7 || i == 14)) begin
        n_bad++;
        $display("FAIL legal_step%0d: got vld=%0b b=%0d wrap=%0b, want vld=1 b=%0d wrap=%0b",
                 i, bus.vld, bus.b, bus.wrap, exp_b, (i == 7 || i == 14));
      end
    end
    n_cmp++;
    if (wraps != 2 || bus.wcnt !== 8'd2 || bus.err !== 1'b0) begin
      n_bad++;
      $display("FAIL legal_totals: got wraps=%0d wcnt=%0d err=%0b, want 2 2 0",
               wraps, bus.wcnt, bus.err);
    end
  endtask

  task automatic test_skip_fault();
    step(3'b000, 1'b0, 1'b1);
    step(3'b000, 1'b0, 1'b0);
    step(3'b001, 1'b0, 1'b0);
    step(3'b011, 1'b0, 1'b0);
    step(3'b110, 1'b0, 1'b0);
    n_cmp++;
    if (bus.err !== 1'b1 || bus.vld !== 1'b0 || bus.b !== 3'd2) begin
      n_bad++;
      $display("FAIL skip_fault: got err=%0b vld=%0b b=%0d, want err=1 vld=0 b=2",
               bus.err, bus.vld, bus.b);
    end
    for (int k = 0; k < 10; k++) begin
      step(SEQ[(5 + k) % 7], 1'b0, 1'b0);
      n_cmp++;
      if (bus.err !== 1'b1 || bus.vld !== 1'b0 || bus.b !== 3'd2) begin
        n_bad++;
        $display("FAIL fault_sticky%0d: got err=%0b vld=%0b b=%0d, want err=1 vld=0 b=2",
                 k, bus.err, bus.vld, bus.b);
      end
    end
  endtask

  task automatic test_resync();
    step(3'b111, 1'b1, 1'b0);
    n_cmp++;
    if (bus.err !== 1'b0 || bus.vld !== 1'b0 || bus.b !== 3'd2) begin
      n_bad++;
      $display("FAIL resync_rs: got err=%0b vld=%0b b=%0d, want err=0 vld=0 b=2",
               bus.err, bus.vld, bus.b);
    end
    step(3'b101, 1'b0, 1'b0);
    n_cmp++;
    if (bus.vld !== 1'b1 || bus.b !== 3'd6 || bus.err !== 1'b0) begin
      n_bad++;
      $display("FAIL resync_accept: got vld=%0b b=%0d err=%0b, want vld=1 b=6 err=0",
               bus.vld, bus.b, bus.err);
    end
  endtask

  task automatic test_illegal();
    step(3'b000, 1'b0, 1'b1);
    step(3'b100, 1'b0, 1'b0);
    n_cmp++;
    if (bus.ill !== 1'b1 || bus.err !== 1'b0 || bus.vld !== 1'b0) begin
      n_bad++;
      $display("FAIL ill_sync: got ill=%0b err=%0b vld=%0b, want 1 0 0", bus.ill, bus.err, bus.vld);
    end
    step(3'b000, 1'b0, 1'b0);
    n_cmp++;
    if (bus.ill !== 1'b0 || bus.vld !== 1'b1 || bus.b !== 3'd0) begin
      n_bad++;
      $display("FAIL ill_single_pulse: got ill=%0b vld=%0b b=%0d, want 0 1 0", bus.ill, bus.vld, bus.b);
    end
    step(3'b100, 1'b0, 1'b0);
    n_cmp++;
    if (bus.ill !== 1'b1 || bus.err !== 1'b1 || bus.vld !== 1'b0) begin
      n_bad++;
      $display("FAIL ill_track: got ill=%0b err=%0b vld=%0b, want 1 1 0", bus.ill, bus.err, bus.vld);
    end
    step(3'b001, 1'b0, 1'b0);
    n_cmp++;
    if (bus.ill !== 1'b0 || bus.err !== 1'b1) begin
      n_bad++;
      $display("FAIL ill_after_fault: got ill=%0b err=%0b, want 0 1", bus.ill, bus.err);
    end
  endtask

  task automatic test_saturation();
    step(3'b000, 1'b0, 1'b1);
    step(3'b000, 1'b0, 1'b0);
    for (int n = 0; n < 255 * 7; n++) step(SEQ[(n + 1) % 7], 1'b0, 1'b0);
    n_cmp++;
    if (bus.wcnt !== 8'd255 || bus.b !== 3'd0) begin
      n_bad++;
      $display("FAIL sat_preload: got wcnt=%0d b=%0d, want 255 0", bus.wcnt, bus.b);
    end
    for (int n = 1; n <= 7; n++) step(SEQ[n % 7], 1'b0, 1'b0);
    n_cmp++;
    if (bus.wrap !== 1'b1 || bus.wcnt !== 8'd255 || bus.err !== 1'b0) begin
      n_bad++;
      $display("FAIL sat_hold: got wrap=%0b wcnt=%0d err=%0b, want 1 255 0",
               bus.wrap, bus.wcnt, bus.err);
    end
  endtask

  task automatic test_clr_priority();
    step(3'b000, 1'b0, 1'b1);
    step(3'b000, 1'b0, 1'b0);
    for (int n = 0; n < 5 * 7; n++) step(SEQ[(n + 1) % 7], 1'b0, 1'b0);
    step(3'b000, 1'b0, 1'b0);
    n_cmp++;
    if (bus.wcnt !== 8'd5 || bus.err !== 1'b1) begin
      n_bad++;
      $display("FAIL clr_setup: got wcnt=%0d err=%0b, want 5 1", bus.wcnt, bus.err);
    end
    step(3'b001, 1'b1, 1'b1);
    n_cmp++;
    if ({bus.b, bus.vld, bus.wrap, bus.wcnt, bus.err, bus.ill} !== 16'h0000) begin
      n_bad++;
      $display("FAIL clr_rs_fault: got b=%0d vld=%0b wrap=%0b wcnt=%0d err=%0b ill=%0b, want all 0",
               bus.b, bus.vld, bus.wrap, bus.wcnt, bus.err, bus.ill);
    end
`ifdef GRAY_MON_SEG7_EN
    n_cmp++;
    if (bus.seg !== 7'b1111110) begin
      n_bad++;
      $display("FAIL clr_seg: got %b want 1111110", bus.seg);
    end
`endif
    step(3'b001, 1'b0, 1'b0);
    n_cmp++;
    if (bus.b !== 3'd1 || bus.vld !== 1'b1) begin
      n_bad++;
      $display("FAIL clr_then_accept: got b=%0d vld=%0b, want 1 1", bus.b, bus.vld);
    end
`ifdef GRAY_MON_SEG7_EN
    n_cmp++;
    if (bus.seg !== 7'b0110000) begin
      n_bad++;
      $display("FAIL seg_one: got %b want 0110000", bus.seg);
    end
`endif
  endtask

  task automatic test_random();
    int r;
    logic [2:0] gv;
    for (int n = 0; n < 600; n++) begin
      r  = int'($urandom_range(0, 99));
      gv = 3'($urandom_range(0, 7));
      if (r < 80)      step(SEQ[(m_gq + 1) % 7], 1'b0, 1'b0);
      else if (r < 90) step(gv, 1'b0, 1'b0);
      else if (r < 97) step(gv, 1'b1, 1'b0);
      else             step(gv, ($urandom_range(0, 1) == 1), 1'b1);
      n_cmp++;
      if ({bus.b, bus.vld, bus.wrap, bus.wcnt, bus.err, bus.ill} !==
          {m_b, (m_mode == 1), m_wrap, m_wcnt, m_err, m_ill}) begin
        n_bad++;
        $display("FAIL random%0d: got b=%0d vld=%0b wrap=%0b wcnt=%0d err=%0b ill=%0b, want b=%0d vld=%0b wrap=%0b wcnt=%0d err=%0b ill=%0b",
                 n, bus.b, bus.vld, bus.wrap, bus.wcnt, bus.err, bus.ill,
                 m_b, (m_mode == 1), m_wrap, m_wcnt, m_err, m_ill);
      end
`ifdef GRAY_MON_SEG7_EN
      n_cmp++;
      if (bus.seg !== SEG[m_b]) begin
        n_bad++;
        $display("FAIL random_seg%0d: got %b want %b", n, bus.seg, SEG[m_b]);
      end
`endif
    end
  endtask

  initial begin
    bus.g  = 3'b000;
    bus.rs = 1'b0;
    clr    = 1'b1;
    test_reset();
    test_legal_sequence();
    test_skip_fault();
    test_resync();
    test_illegal();
    test_saturation();
    test_clr_priority();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
